// File: rtl/timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter_if
// Description : Request/grant/status bundle between the requesters and the
//               shared delay timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_arbiter_if #(
    parameter int REQ_NUM     = 4,
    parameter int DELAY_WIDTH = 16
);
    localparam int OWNER_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [REQ_NUM-1:0]             req_valid_i;
    logic [REQ_NUM*DELAY_WIDTH-1:0] req_delay_i;
    logic [REQ_NUM-1:0]             req_ready_o;
    logic [REQ_NUM-1:0]             done_o;
    logic                           busy_o;
    logic [OWNER_WIDTH-1:0]         owner_o;
    logic [DELAY_WIDTH-1:0]         count_o;

    // Requester side: raises requests, observes grant and timer status.
    modport master (
        output req_valid_i,
        output req_delay_i,
        input  req_ready_o,
        input  done_o,
        input  busy_o,
        input  owner_o,
        input  count_o
    );

    // Timer side: arbitrates requests and reports status.
    modport slave (
        input  req_valid_i,
        input  req_delay_i,
        output req_ready_o,
        output done_o,
        output busy_o,
        output owner_o,
        output count_o
    );
endinterface
`default_nettype wire

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timer_arbiter
// Description : One down-counting delay timer shared round-robin between
//               REQ_NUM requesters; pulses the owner's done line on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
    parameter int REQ_NUM     = 4,
    parameter int DELAY_WIDTH = 16
) (
    input  logic           clk_i,
    input  logic           s_rst_i,
    timer_arbiter_if.slave bus
);
    localparam int c_OWNER_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    // One extra bit so pointer+offset never overflows before the modulo fold.
    localparam logic [c_OWNER_WIDTH:0]   c_REQ_NUM = (c_OWNER_WIDTH+1)'(REQ_NUM);
    localparam logic [DELAY_WIDTH-1:0]   c_ONE     = DELAY_WIDTH'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]               r_state;
    logic [c_OWNER_WIDTH-1:0] r_ptr;
    logic [c_OWNER_WIDTH-1:0] r_owner;
    logic [DELAY_WIDTH-1:0]   r_count;

    logic [DELAY_WIDTH-1:0]   w_delay [REQ_NUM];
    logic                     w_found;
    logic [c_OWNER_WIDTH-1:0] w_win;
    logic [c_OWNER_WIDTH:0]   w_sum;
    logic [c_OWNER_WIDTH:0]   w_ptr_sum;
    logic [c_OWNER_WIDTH-1:0] w_next_ptr;
    logic                     w_grant;
    logic [REQ_NUM-1:0]       w_ready;
    logic [REQ_NUM-1:0]       w_done;

    // Per-requester views of the packed delay bus, grant and done decode.
    generate
        for (genvar k = 0; k < REQ_NUM; k++) begin : g_req
            assign w_delay[k] = bus.req_delay_i[k*DELAY_WIDTH +: DELAY_WIDTH];
            assign w_ready[k] = w_grant && (w_win == c_OWNER_WIDTH'(k));
            assign w_done[k]  = (r_state == c_ST_DONE) && (r_owner == c_OWNER_WIDTH'(k));
        end
    endgenerate

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_sum = {1'b0, r_ptr} + (c_OWNER_WIDTH+1)'(i);
            if (w_sum >= c_REQ_NUM) begin
                w_sum = w_sum - c_REQ_NUM;
            end
            if (!w_found && bus.req_valid_i[w_sum[c_OWNER_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_OWNER_WIDTH-1:0];
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping.
    always_comb begin
        w_ptr_sum  = {1'b0, w_win} + (c_OWNER_WIDTH+1)'(1);
        w_next_ptr = w_ptr_sum[c_OWNER_WIDTH-1:0];
        if (w_ptr_sum >= c_REQ_NUM) begin
            w_next_ptr = '0;
        end
    end

    // Grant only from IDLE; suppressed during reset so no transfer can slip in.
    assign w_grant = (r_state == c_ST_IDLE) && w_found && !s_rst_i;

    // Timer FSM: capture on handshake, count down, one-cycle done, back to idle.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_count <= w_delay[w_win];
                        r_owner <= w_win;
                        r_ptr   <= w_next_ptr;
                        r_state <= (w_delay[w_win] == '0) ? c_ST_DONE : c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // Saturating decrement: the last step lands on zero and leaves.
                    if (r_count <= c_ONE) begin
                        r_count <= '0;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_count <= r_count - c_ONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.done_o      = w_done;
    assign bus.busy_o      = (r_state != c_ST_IDLE);
    assign bus.owner_o     = r_owner;
    assign bus.count_o     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_arbiter
// Description : Scoreboard bench for timer_arbiter with a timeline reference
//               model (grant time + delay arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic s_rst_i;
    always #5 clk = ~clk;

    timer_arbiter_if #(.REQ_NUM(N), .DELAY_WIDTH(DW)) bus ();

    timer_arbiter #(.REQ_NUM(N), .DELAY_WIDTH(DW)) dut (
        .clk_i   (clk),
        .s_rst_i (s_rst_i),
        .bus     (bus)
    );

    typedef struct {
        int owner;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];
    int   gcyc[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: timer is free once grant time + D + 2 is reached.
    bit            m_active = 1'b0;
    int            m_T = 0;
    int            m_D = 0;
    int            m_ptr = 0;
    int            m_owner = 0;
    int            m_owner_next = 0;
    bit            prev_rst = 1'b1;
    logic [N-1:0]  want_v;
    logic [DW-1:0] want_d [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input bit rst);
        int            c;
        int            win;
        logic [N-1:0]  exp_ready;
        logic [N*DW-1:0] packed_d;
        @(posedge clk);
        #1;
        if (prev_rst) begin
            m_active     = 1'b0;
            m_ptr        = 0;
            m_owner      = 0;
            m_owner_next = 0;
            exp_q.delete();
        end
        m_owner = m_owner_next;
        if (m_active && cyc >= m_T + m_D + 2) m_active = 1'b0;
        s_rst_i  = rst;
        prev_rst = rst;
        for (int k = 0; k < N; k++) packed_d[k*DW +: DW] = want_d[k];
        bus.req_valid_i = want_v;
        bus.req_delay_i = packed_d;
        #1;
        c = cyc - m_T;
        check("busy",  {31'd0, bus.busy_o}, {31'd0, (m_active && c >= 1)});
        check("count", {16'd0, bus.count_o},
              (m_active && c >= 1 && c <= m_D) ? (m_D - c + 1) : 0);
        check("owner", {30'd0, bus.owner_o}, m_owner);
        exp_ready = '0;
        win       = -1;
        if (!m_active && !rst) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (win < 0 && want_v[k]) win = k;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        check("ready", {28'd0, bus.req_ready_o}, {28'd0, exp_ready});
        if (win >= 0) begin
            m_active     = 1'b1;
            m_T          = cyc;
            m_D          = int'(want_d[win]);
            m_ptr        = (win + 1) % N;
            m_owner_next = win;
            exp_q.push_back('{win, cyc + m_D + 1});
            glog.push_back(win);
            gcyc.push_back(cyc);
            want_v[win] = 1'b0;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL done_missing cycle %0d: owner %0d expected done at %0d", cyc, e.owner, e.cyc);
            end
            if (bus.done_o !== '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected cycle %0d: got %0h expected 0", cyc, bus.done_o);
                end else begin
                    e = exp_q.pop_front();
                    check("done_vec",   {28'd0, bus.done_o}, 32'd1 << e.owner);
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        s_rst_i         = 1'b1;
        want_v          = '0;
        for (int k = 0; k < N; k++) want_d[k] = '0;
        bus.req_valid_i = '0;
        bus.req_delay_i = '0;

        repeat (3) tick(1'b1);
        tick(1'b0);

        // Single request, delay 5.
        want_d[0] = 16'd5;
        want_v[0] = 1'b1;
        repeat (10) tick(1'b0);

        // Zero delay.
        want_d[2] = 16'd0;
        want_v[2] = 1'b1;
        repeat (4) tick(1'b0);

        // All four at once after reset: order 0,1,2,3, four cycles apart.
        tick(1'b1);
        tick(1'b0);
        glog.delete();
        gcyc.delete();
        for (int k = 0; k < N; k++) want_d[k] = 16'd2;
        want_v = 4'hF;
        repeat (18) tick(1'b0);
        check("rr_count", glog.size(), 4);
        for (int k = 0; k < 4 && k < glog.size(); k++) check("rr_order", glog[k], k);
        for (int k = 0; k < 3 && k + 1 < gcyc.size(); k++) check("rr_gap", gcyc[k+1] - gcyc[k], 4);

        // Requesters 1 and 3 held continuously: strict alternation.
        glog.delete();
        want_d[1] = 16'd1;
        want_d[3] = 16'd1;
        for (int t = 0; t < 24; t++) begin
            want_v[1] = 1'b1;
            want_v[3] = 1'b1;
            tick(1'b0);
        end
        want_v = '0;
        check("alt_count_ok", {31'd0, glog.size() >= 6}, 32'd1);
        for (int k = 0; k < glog.size(); k++) check("alt_order", glog[k], (k % 2 == 0) ? 1 : 3);
        repeat (6) tick(1'b0);

        // Reset while counting a delay of 10, at count 4.
        want_d[1] = 16'd10;
        want_v[1] = 1'b1;
        for (int i = 0; i < 20 && !(m_active && m_D == 10 && cyc - m_T == 6); i++) tick(1'b0);
        tick(1'b1);
        check("rst_at_count4", {16'd0, bus.count_o}, 32'd4);
        tick(1'b0);
        glog.delete();
        want_d[0] = 16'd3;
        want_d[1] = 16'd3;
        want_v    = 4'b0011;
        repeat (12) tick(1'b0);
        check("rst_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            check("rst_first", glog[0], 0);
            check("rst_second", glog[1], 1);
        end

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 1500; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!want_v[k]) begin
                    want_d[k] = DW'($urandom);
                    if ($urandom_range(0, 3) == 0) begin
                        want_v[k] = 1'b1;
                        want_d[k] = DW'($urandom_range(0, 6));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    want_v[k] = 1'b0;
                end
            end
            tick($urandom_range(0, 199) == 0);
        end
        want_v = '0;
        repeat (10) tick(1'b0);

        // Maximum delay.
        want_d[2] = 16'hFFFF;
        want_v[2] = 1'b1;
        repeat (65545) tick(1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
Shares one down-counting delay timer between REQ_NUM requesters. Each requester asks for a delay of D clock cycles through a valid/ready handshake. A round-robin arbiter grants the timer to one requester, loads it with D and counts it down. The block then pulses that requester's done line. It sits beside the free-running counters in the timing and control layer and replaces per-client timers where their delays never overlap.

Parameters:
REQ_NUM, 4, number of requesters; legal range 1..16.
DELAY_WIDTH, 16, width of a requested delay in cycles.
OWNER_WIDTH, local, $clog2(REQ_NUM) with a minimum of 1; width of owner_o.

Ports:
clk_i  in  1  single clock; all logic is rising-edge.
s_rst_i  in  1  synchronous reset, active-high.
req_valid_i  in  REQ_NUM  bit k is high when requester k wants the timer.
req_delay_i  in  REQ_NUM*DELAY_WIDTH  requested delay; requester k uses slice [k*DELAY_WIDTH +: DELAY_WIDTH].
req_ready_o  out  REQ_NUM  one-hot grant; a transfer happens on a cycle where valid[k] and ready[k] are both high.
done_o  out  REQ_NUM  one-cycle pulse to the owner when its delay expires.
busy_o  out  1  high while the timer is owned (RUN or DONE).
owner_o  out  OWNER_WIDTH  index of the current or most recent grantee.
count_o  out  DELAY_WIDTH  remaining count.

Behaviour:
- Reset values (s_rst_i sampled high at a clock edge): state IDLE, req_ready_o=0, done_o=0, busy_o=0, owner_o=0, count_o=0, round-robin pointer=0 (requester 0 has highest priority).
- States are IDLE, RUN and DONE.
- IDLE:
  - Search starts at the pointer and wraps modulo REQ_NUM; the first k with req_valid_i[k]=1 wins.
  - req_ready_o[k] for the winner is driven combinationally in the same cycle. All other ready bits are 0, and all are 0 when no valid is high.
  - On the handshake edge: capture the winner's delay slice into count, set owner_o=k, set pointer=(k+1) mod REQ_NUM.
  - Next state is RUN if the captured delay is nonzero, otherwise DONE.
- RUN:
  - count decrements by 1 each cycle.
  - When count==1, the next state is DONE and count becomes 0.
  - count never underflows and never wraps.
- DONE:
  - done_o[owner]=1 for exactly one cycle; all other done bits are 0.
  - Next state is IDLE.
- Latency: handshake on cycle T gives the done pulse on cycle T+D+1 for every D ≥ 0, including D=0.
- Back-to-back grants are at least D+2 cycles apart. The IDLE cycle that follows DONE can grant again immediately.
- busy_o is high in RUN and DONE, and low in IDLE.
- owner_o holds its last value through IDLE.
- req_ready_o is 0 in RUN and DONE.
- Requester rules:
  - A requester holds valid and delay stable until it sees ready.
  - Dropping valid before the handshake is legal and leaves no state behind.
  - Dropping valid or changing the delay after the handshake does not cancel or alter the running delay.
- Reset mid-operation (RUN or DONE): the state returns to IDLE and every output takes its reset value on the next cycle. No done pulse is emitted for the aborted delay. The pointer returns to 0.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority apart from the reset pointer value.
- With REQ_NUM=1 the pointer stays 0 and owner_o stays 0.

Test Plan:
1. Reset, then valid[0]=1 with delay 5, handshake on cycle T -> ready[0]=1 on T only; count_o 5,4,3,2,1 on T+1..T+5; done_o[0] pulses on T+6; busy_o high T+1..T+6.
2. valid[2]=1 with delay 0, handshake on T -> done_o[2] on T+1, count_o=0, busy_o high for 1 cycle; IDLE on T+2.
3. All 4 valid, each with delay 2, held -> grants go to 0,1,2,3 on cycles T, T+4, T+8, T+12; each done arrives 3 cycles after its grant; owner_o tracks each grant.
4. valid[1] and valid[3] held continuously after a grant to 3 -> grant order alternates 1,3,1,3 and requester 3 is never starved.
5. Delay 10 to requester 1, s_rst_i high for one cycle at count_o=4 -> next cycle all outputs are 0 and done_o[1] never fires; a following request from requester 0 and requester 1 together grants requester 0 first.
6. Delay 16'hFFFF -> done on T+65536, count_o never wraps past 0, no spurious ready during RUN.
